// File: rtl/step_input_ctrl_pkg.sv
// Shared types and defaults for the board-input conditioning stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package step_input_ctrl_pkg;

   // Run-mode state encoding
   typedef enum logic [0:0] {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_e;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_CYCLES   = 500000;    // 5 ms at 100 MHz
   localparam int DEF_AUTO_DIV    = 25000000;  // 4 Hz at 100 MHz
   localparam int STEP_CNT_W      = 16;

   // Counter width for a modulus of n; a modulus of 1 still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw push-button, debounces it and emits a press pulse.
// Latency: press high the cycle after edge SYNC_STAGES+DB_CYCLES (edge 0 samples the new level).
// Backpressure: none; the pulse is lost if nothing consumes it.
//
// Ports: clk/rst (async active-low), btn raw level, press one-cycle rising-edge pulse.
module button_debounce
   import step_input_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int            CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   stable_q;
   logic                   stable_d_q;
   logic [CW-1:0]          cnt_q;
   logic                   lvl;

   assign lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= '0;
         stable_q   <= 1'b0;
         stable_d_q <= 1'b0;
         cnt_q      <= '0;
         press      <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};

         // Any agreement with the stable level restarts the stability window.
         if (lvl == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= lvl;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end

         // Registered edge detect keeps the pulse off any combinational path.
         stable_d_q <= stable_q;
         press      <= stable_q & ~stable_d_q;
      end
   end

endmodule

// File: rtl/step_input_ctrl.sv
// Conditions board buttons/switches and generates the processor step enable.
// Latency: sw_sync SYNC_STAGES edges; manual step_en after edge SYNC_STAGES+DB_CYCLES+1.
// Backpressure: none; step_en is a free-running one-cycle strobe.
//
// Ports: clk/rst (async active-low), btn_step/btn_mode raw buttons, sw raw switches,
//        sw_sync synchronised switches, step_en strobe, auto_mode run mode,
//        step_cnt wrapping count of step_en pulses.
module step_input_ctrl
   import step_input_ctrl_pkg::*;
#(
   parameter int N_SW        = 5,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int AUTO_DIV    = DEF_AUTO_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_step,
   input  logic                  btn_mode,
   input  logic [N_SW-1:0]       sw,
   output logic [N_SW-1:0]       sw_sync,
   output logic                  step_en,
   output logic                  auto_mode,
   output logic [STEP_CNT_W-1:0] step_cnt
);

   localparam logic [0:0] ST_MANUAL = MANUAL;
   localparam logic [0:0] ST_AUTO   = AUTO;

   localparam int            DW       = cnt_width(AUTO_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

   logic                              press_step;
   logic                              press_mode;
   logic [SYNC_STAGES-1:0][N_SW-1:0]  sw_pipe;
   logic [0:0]                        state_q;
   logic [DW-1:0]                     div_q;
   logic                              div_wrap;
   logic                              next_step;

   button_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_db_step (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_step),
      .press (press_step)
   );

   button_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_db_mode (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .press (press_mode)
   );

   // Switches are level inputs for the display path; synchronise only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_pipe <= '0;
      end else begin
         sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], sw};
      end
   end

   assign sw_sync  = sw_pipe[SYNC_STAGES-1];
   assign div_wrap = (div_q == DIV_LAST);

   // The step decision uses only the current state, so a mode press in the
   // same cycle neither suppresses a due auto step nor a manual press.
   always_comb begin
      next_step = 1'b0;
      if (state_q == ST_AUTO) begin
         next_step = div_wrap;
      end else begin
         next_step = press_step;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_MANUAL;
         div_q    <= '0;
         step_en  <= 1'b0;
         step_cnt <= '0;
      end else begin
         case (state_q)
            ST_MANUAL: begin
               if (press_mode) begin
                  state_q <= ST_AUTO;
                  div_q   <= '0;
               end
            end
            ST_AUTO: begin
               div_q <= div_wrap ? '0 : div_q + DW'(1);
               if (press_mode) begin
                  state_q <= ST_MANUAL;
               end
            end
            default: begin
               state_q <= ST_MANUAL;
            end
         endcase

         step_en  <= next_step;
         step_cnt <= step_cnt + STEP_CNT_W'(next_step);
      end
   end

   assign auto_mode = (state_q == ST_AUTO);

endmodule

// File: tb/tb_step_input_ctrl.sv
// Randomised and directed bench for step_input_ctrl against a behavioural model.
module tb_step_input_ctrl;

   localparam int N_SW = 5;
   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int DIV  = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            btn_step = 1'b0;
   logic            btn_mode = 1'b0;
   logic [N_SW-1:0] sw = '0;
   logic [N_SW-1:0] sw_sync;
   logic            step_en;
   logic            auto_mode;
   logic [15:0]     step_cnt;

   step_input_ctrl #(
      .N_SW        (N_SW),
      .SYNC_STAGES (SYNC),
      .DB_CYCLES   (DB),
      .AUTO_DIV    (DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_step  (btn_step),
      .btn_mode  (btn_mode),
      .sw        (sw),
      .sw_sync   (sw_sync),
      .step_en   (step_en),
      .auto_mode (auto_mode),
      .step_cnt  (step_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Synchronised levels are the raw pins delayed by SYNC edges; a button is
   // accepted after DB consecutive differing edges; an accepted press acts on
   // the mode logic two edges later. Auto steps fall every DIV edges after entry.
   bit              hist_s[$];
   bit              hist_m[$];
   logic [N_SW-1:0] hist_sw[$];
   int              edge_no;
   int              run_s, run_m;
   bit              deb_s, deb_m;
   int              press_s_at[$];
   int              press_m_at[$];
   bit              m_auto;
   int              m_since;
   bit              m_step;
   logic [15:0]     m_cnt;
   logic [N_SW-1:0] m_sw;
   bit              preload = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_s.delete(); hist_m.delete(); hist_sw.delete();
         press_s_at.delete(); press_m_at.delete();
         edge_no = 0; run_s = 0; run_m = 0; deb_s = 0; deb_m = 0;
         m_auto = 0; m_since = 0; m_step = 0; m_cnt = '0; m_sw = '0;
      end else begin
         bit lvl_s, lvl_m, ps, pm;
         edge_no++;

         // presses that reach the mode logic on this edge
         ps = (press_s_at.size() > 0) && (press_s_at[0] == edge_no);
         if (ps) void'(press_s_at.pop_front());
         pm = (press_m_at.size() > 0) && (press_m_at[0] == edge_no);
         if (pm) void'(press_m_at.pop_front());

         hist_s.push_back(btn_step);
         hist_m.push_back(btn_mode);
         if (hist_s.size() > SYNC + 1) void'(hist_s.pop_front());
         if (hist_m.size() > SYNC + 1) void'(hist_m.pop_front());
         lvl_s = (hist_s.size() == SYNC + 1) ? hist_s[0] : 1'b0;
         lvl_m = (hist_m.size() == SYNC + 1) ? hist_m[0] : 1'b0;

         if (lvl_s != deb_s) begin
            run_s++;
            if (run_s == DB) begin
               deb_s = lvl_s; run_s = 0;
               if (lvl_s) press_s_at.push_back(edge_no + 2);
            end
         end else run_s = 0;

         if (lvl_m != deb_m) begin
            run_m++;
            if (run_m == DB) begin
               deb_m = lvl_m; run_m = 0;
               if (lvl_m) press_m_at.push_back(edge_no + 2);
            end
         end else run_m = 0;

         if (m_auto) begin
            m_since++;
            m_step = (m_since % DIV == 0);
            if (pm) m_auto = 0;
         end else begin
            m_step = ps;
            if (pm) begin m_auto = 1; m_since = 0; end
         end

         if (preload) m_cnt = 16'hFFFF;
         if (m_step) m_cnt = m_cnt + 16'd1;

         hist_sw.push_back(sw);
         if (hist_sw.size() > SYNC) void'(hist_sw.pop_front());
         m_sw = (hist_sw.size() == SYNC) ? hist_sw[0] : '0;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check_val("step_en",   32'(step_en),   32'(m_step));
      check_val("auto_mode", 32'(auto_mode), 32'(m_auto));
      check_val("step_cnt",  32'(step_cnt),  32'(m_cnt));
      check_val("sw_sync",   32'(sw_sync),   32'(m_sw));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int hs, hm, hw;

      // reset state
      #1;
      check_val("rst_step_en", 32'(step_en), 32'd0);
      check_val("rst_cnt",     32'(step_cnt), 32'd0);
      tick(3);
      rst = 1'b1;
      tick(20);

      // single manual press, then release
      btn_step = 1'b1; tick(15);
      btn_step = 1'b0; tick(15);
      check_val("cnt_after_press", 32'(step_cnt), 32'd1);

      // bouncing step button, then a clean hold
      for (int i = 0; i < 10; i++) begin
         btn_step = ~btn_step; tick(2);
      end
      check_val("cnt_after_bounce", 32'(step_cnt), 32'd1);
      btn_step = 1'b1; tick(15);
      btn_step = 1'b0; tick(15);
      check_val("cnt_after_hold", 32'(step_cnt), 32'd2);

      // auto mode with step presses ignored, then back to manual
      btn_mode = 1'b1; tick(10);
      btn_mode = 1'b0;
      check_val("auto_entered", 32'(auto_mode), 32'd1);
      tick(10);
      btn_step = 1'b1; tick(10);
      btn_step = 1'b0; tick(10);
      btn_mode = 1'b1; tick(10);
      btn_mode = 1'b0; tick(20);
      check_val("auto_left", 32'(auto_mode), 32'd0);

      // counter wrap from a preloaded all-ones value
      @(negedge clk); #1;
      force dut.step_cnt = 16'hFFFF;
      preload = 1'b1;
      @(negedge clk); #1;
      release dut.step_cnt;
      preload = 1'b0;
      btn_step = 1'b1; tick(15);
      btn_step = 1'b0; tick(10);
      check_val("cnt_wrap", 32'(step_cnt), 32'd0);

      // reset during auto run and mid-debounce
      btn_mode = 1'b1; tick(10);
      btn_mode = 1'b0; tick(9);
      btn_step = 1'b1; tick(2);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check_val("arst_step_en",   32'(step_en),   32'd0);
      check_val("arst_auto_mode", 32'(auto_mode), 32'd0);
      check_val("arst_cnt",       32'(step_cnt),  32'd0);
      check_val("arst_sw_sync",   32'(sw_sync),   32'd0);
      btn_step = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(30);
      check_val("post_rst_cnt",  32'(step_cnt),  32'd0);
      check_val("post_rst_mode", 32'(auto_mode), 32'd0);

      // switch synchroniser latency
      sw = 5'b10110;
      @(posedge clk); @(posedge clk); #1;
      check_val("sw_latency", 32'(sw_sync), 32'(5'b10110));
      tick(4);

      // random button and switch activity
      hs = 0; hm = 0; hw = 0;
      repeat (3000) begin
         @(negedge clk);
         if (hs == 0) begin btn_step = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end
         else hs--;
         if (hm == 0) begin btn_mode = 1'($urandom_range(0, 1)); hm = $urandom_range(1, 40); end
         else hm--;
         if (hw == 0) begin sw = N_SW'($urandom); hw = $urandom_range(0, 4); end
         else hw--;
      end
      btn_step = 1'b0; btn_mode = 1'b0;
      tick(20);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/step_input_ctrl.md
# step_input_ctrl

Board-input conditioning stage that sits directly upstream of the FPGA system top. It synchronises and debounces the raw step and mode push-buttons and synchronises the slide switches, all in the 100 MHz board clock domain. It then produces a single-cycle step enable for the processor, either one pulse per manual press or periodic pulses in auto-run mode, plus a wrapping step counter for the display path.

## Interface
Parameters:
- N_SW, 5, number of slide-switch inputs
- SYNC_STAGES, 2, flip-flop synchroniser depth per raw input (≥2)
- DB_CYCLES, 500000, consecutive stable cycles required to accept a button change (5 ms at 100 MHz; ≥1)
- AUTO_DIV, 25000000, clock cycles between step pulses in auto mode (4 Hz; ≥2)

Ports:
- clk  in  1  board clock (100 MHz)
- rst  in  1  reset, asynchronous, active-low
- btn_step  in  1  raw step push-button, active-high, asynchronous to clk
- btn_mode  in  1  raw mode push-button, active-high, asynchronous to clk
- sw  in  N_SW  raw slide switches, asynchronous to clk
- sw_sync  out  N_SW  synchronised switches
- step_en  out  1  one-cycle processor step enable
- auto_mode  out  1  1 = auto-run, 0 = manual single-step
- step_cnt  out  16  number of step_en pulses issued, wraps

## Operation
- Every raw input passes through its own SYNC_STAGES-deep synchroniser. sw_sync is the last synchroniser stage; the switches are not debounced.
- Each button has a debouncer made of a stable-level register and a counter:
  - synchronised level == stable → counter cleared.
  - synchronised level != stable → counter increments.
  - When the counter reaches DB_CYCLES-1 while the levels still differ, the stable level flips and the counter clears.
  - Any bounce back to the stable level clears the counter.
- A rising edge of the debounced level (registered previous value) gives a one-cycle press pulse: press_step or press_mode.
- Mode FSM, two states:
  - MANUAL: press_mode → AUTO, with the divider cleared to 0. press_step → step_en.
  - AUTO: press_mode → MANUAL. The divider counts 0..AUTO_DIV-1 and wraps; step_en is asserted on the wrap. press_step is ignored.
- auto_mode = (state == AUTO).
- step_cnt increments by 1 on every step_en and wraps 0xFFFF → 0x0000.
- Simultaneous press_mode and press_step: step_en is decided by the current state only. The mode change takes effect the next cycle.
- Leaving AUTO in the same cycle the divider wraps: that step_en is still issued.
- Releasing a button never produces a pulse.

## Timing
- Reset (rst low, asynchronous) sets every register to 0:
  - synchroniser stages, debounce stable levels and counters, divider, step_cnt
  - state = MANUAL
  - step_en = 0, auto_mode = 0, sw_sync = 0
- Operation resumes on the first clk edge after rst deasserts. A button held through reset is seen as a new press once debounced.
- Reset mid-press or mid-auto aborts everything: no pending pulse survives.
- All outputs are registered; there is no combinational path from input to output.
- Press latency: with edge 0 as the first clk edge sampling the new raw level, step_en is high exactly during the cycle after edge SYNC_STAGES+DB_CYCLES+1, for one cycle.
- sw_sync latency: SYNC_STAGES edges.
- AUTO: the first step_en comes AUTO_DIV cycles after the AUTO entry edge, then every AUTO_DIV cycles; it is never high for two consecutive cycles.
- auto_mode changes on the edge after press_mode.

## Structure
- Shared package holds:
  - mode state enum MANUAL = 0, AUTO = 1
  - default constants for DB_CYCLES, AUTO_DIV, SYNC_STAGES
  - step_cnt width of 16
- One sub-module, `button_debounce` (synchroniser + debounce counter + rising-edge pulse, parameterised by SYNC_STAGES and DB_CYCLES), instantiated twice. The switch synchronisers, FSM, divider and counter live in the top.
- Counter widths are $clog2 of the parameters.

## Test plan
Run with DB_CYCLES=4, AUTO_DIV=8, SYNC_STAGES=2:
- Reset released, no inputs → step_en=0, auto_mode=0, step_cnt=0, sw_sync=0 for 20 cycles.
- btn_step rises and holds → step_en=1 for exactly the cycle after edge 7, step_cnt=1. Release → no further pulse.
- btn_step toggles every 2 cycles for 20 cycles, then holds → exactly one step_en, only after 4 stable cycles.
- btn_mode press → auto_mode=1. step_en at 8, 16, 24 cycles after entry; step_cnt=3. Pressing btn_step during AUTO changes nothing. Second btn_mode press → auto_mode=0, pulses stop.
- step_cnt preloaded (force) to 0xFFFF, one manual press → step_cnt=0x0000.
- rst asserted mid-AUTO and mid-debounce, 3 cycles after a divider restart → all outputs 0 immediately (asynchronously), state MANUAL, no step_en after release.
- sw=5'b10110 → sw_sync=5'b10110 after 2 edges.
